// File: rtl/pc_unit_ras.sv
// pc_unit_ras
//   Program-counter unit. It holds the PC and selects the next PC from one of
//   four sources: the increment, the address adder, the data bus, or the top of
//   a small return-address stack (RAS). The PC loads only when i_ld_pc is high.
//   The RAS is a circular buffer addressed by a top pointer that wraps mod
//   RAS_DEPTH. When the stack is full, a push silently overwrites the oldest
//   entry.
//
// Ports
//   i_clk            system clock; all state changes on the rising edge
//   i_reset          synchronous active-high reset
//   i_ld_pc          load the PC with the selected next value at this edge
//   i_pcmux_sel      00 PC+INC, 01 adder, 10 bus, 11 RAS pop
//   i_push           push PC+INC onto the RAS (qualified by i_ld_pc)
//   i_adder_in       address-adder result
//   i_bus_in         data-bus value
//   o_pc             current PC (registered)
//   o_pc_inc         PC+INC mod 2^WIDTH (combinational from the PC)
//   o_ras_empty      stack holds no valid entries
//   o_ras_full       stack holds RAS_DEPTH valid entries
//   o_ras_count      number of valid stack entries
//   o_ras_underflow  sticky; set when a pop is attempted on an empty stack
module pc_unit_ras #(
  parameter int               WIDTH     = 16,
  parameter int               RAS_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               INC       = 1
) (
  input  logic                           i_clk,
  input  logic                           i_reset,
  input  logic                           i_ld_pc,
  input  logic [1:0]                     i_pcmux_sel,
  input  logic                           i_push,
  input  logic [WIDTH-1:0]               i_adder_in,
  input  logic [WIDTH-1:0]               i_bus_in,
  output logic [WIDTH-1:0]               o_pc,
  output logic [WIDTH-1:0]               o_pc_inc,
  output logic                           o_ras_empty,
  output logic                           o_ras_full,
  output logic [$clog2(RAS_DEPTH):0]     o_ras_count,
  output logic                           o_ras_underflow
);

  localparam int               PTR_W   = $clog2(RAS_DEPTH);
  localparam int               CNT_W   = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RAS_DEPTH);
  localparam logic [WIDTH-1:0] INC_W   = WIDTH'(INC);

  logic [WIDTH-1:0] r_pc;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PTR_W-1:0] r_top;       // index of the most recently pushed entry
  logic [CNT_W-1:0] r_count;
  logic             r_underflow;

  logic [WIDTH-1:0] w_pc_inc;
  logic [WIDTH-1:0] w_top_val;
  logic [PTR_W-1:0] w_top_up;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic [WIDTH-1:0] w_pc_next;
  logic             w_wr_en;
  logic [PTR_W-1:0] w_wr_idx;
  logic [PTR_W-1:0] w_top_next;
  logic [CNT_W-1:0] w_count_next;
  logic             w_uf_set;

  assign w_pc_inc  = r_pc + INC_W;  // wraps naturally at WIDTH bits
  assign w_top_val = r_ras[r_top];
  assign w_top_up  = r_top + 1'b1;
  assign w_empty   = (r_count == '0);
  assign w_full    = (r_count == DEPTH_C);
  assign w_pop     = i_ld_pc && (i_pcmux_sel == 2'b11);
  assign w_push    = i_ld_pc && i_push;

  // Next-PC select. A pop on an empty stack falls back to the increment.
  always_comb begin
    w_pc_next = w_pc_inc;
    case (i_pcmux_sel)
      2'b01:   w_pc_next = i_adder_in;
      2'b10:   w_pc_next = i_bus_in;
      2'b11:   w_pc_next = w_empty ? w_pc_inc : w_top_val;
      default: w_pc_next = w_pc_inc;
    endcase
  end

  // Stack pointer / count / write control.
  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_idx     = r_top;
    w_top_next   = r_top;
    w_count_next = r_count;
    w_uf_set     = 1'b0;
    if (w_pop) begin
      if (w_empty) begin
        w_uf_set = 1'b1;
        if (w_push) begin
          w_wr_en      = 1'b1;
          w_wr_idx     = w_top_up;
          w_top_next   = w_top_up;
          w_count_next = CNT_W'(1);
        end
      end else if (w_push) begin
        // Combined call-and-return: replace the top in place.
        w_wr_en  = 1'b1;
        w_wr_idx = r_top;
      end else begin
        w_top_next   = r_top - 1'b1;
        w_count_next = r_count - 1'b1;
      end
    end else if (w_push) begin
      // When full, advancing the pointer lands on the oldest entry, so the
      // circular write overwrites it and the count saturates.
      w_wr_en      = 1'b1;
      w_wr_idx     = w_top_up;
      w_top_next   = w_top_up;
      w_count_next = w_full ? r_count : r_count + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_pc        <= RESET_VEC;
      r_top       <= '0;
      r_count     <= '0;
      r_underflow <= 1'b0;
    end else if (i_ld_pc) begin
      r_pc        <= w_pc_next;
      r_top       <= w_top_next;
      r_count     <= w_count_next;
      r_underflow <= r_underflow | w_uf_set;
    end
  end

  // Stack storage. Entries above the count are don't-care, so reset leaves
  // them alone.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_wr_en) begin
      r_ras[w_wr_idx] <= w_pc_inc;
    end
  end

  assign o_pc            = r_pc;
  assign o_pc_inc        = w_pc_inc;
  assign o_ras_empty     = w_empty;
  assign o_ras_full      = w_full;
  assign o_ras_count     = r_count;
  assign o_ras_underflow = r_underflow;

endmodule
